// File: rtl/sum_window_accumulator.sv
// Accumulates up to WINDOW unsigned sum samples into a saturating total and
// presents total, sample count and saturation flag until the consumer accepts.
module sum_window_accumulator #(
  parameter int DATA_W = 8,
  parameter int WINDOW = 4,
  parameter int ACC_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic [ACC_W-1:0]  out_sum,
  output logic [7:0]        out_count,
  output logic              out_sat,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t            state, state_next;
  logic [ACC_W-1:0]  acc, acc_next;
  logic [7:0]        cnt, cnt_next;
  logic              sat, sat_next;
  logic [ACC_W:0]    in_ext;
  logic [ACC_W:0]    acc_sum;
  logic              accept;
  logic              rel;
  logic              close;

  assign in_ext    = {{(ACC_W + 1 - DATA_W){1'b0}}, in_data};
  assign acc_sum   = {1'b0, acc} + in_ext;
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid & in_ready;
  assign rel       = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
      sat   <= 1'b0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      cnt   <= cnt_next;
      sat   <= sat_next;
    end
  end

  // A carry out of the accumulator clamps it to all-ones and marks the window saturated.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    cnt_next   = cnt;
    sat_next   = sat;
    close      = 1'b0;
    case (state)
      ACCUM: begin
        if (accept) begin
          acc_next = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
          cnt_next = cnt + 8'd1;
          sat_next = sat | acc_sum[ACC_W];
        end
        if ((accept && (cnt == 8'(WINDOW - 1))) || (flush && ((cnt != 8'd0) || accept))) begin
          close      = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (rel) begin
          acc_next   = '0;
          cnt_next   = '0;
          sat_next   = 1'b0;
          state_next = ACCUM;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  // Result fields are captured once on entry to HOLD so they stay stable until released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_sum   <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
    end else if (close) begin
      out_sum   <= acc_next;
      out_count <= cnt_next;
      out_sat   <= sat_next;
    end
  end

endmodule

// File: tb/tb_sum_window_accumulator.sv
// Drives two accumulators (12-bit and 8-bit totals) with shared stimulus and
// compares both against a window-level reference model.
module tb_sum_window_accumulator;

  localparam int WINDOW = 4;
  localparam int MAX_A  = 4095;
  localparam int MAX_B  = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;

  logic        in_ready_a, out_sat_a, out_valid_a;
  logic [11:0] out_sum_a;
  logic [7:0]  out_count_a;
  logic        in_ready_b, out_sat_b, out_valid_b;
  logic [7:0]  out_sum_b;
  logic [7:0]  out_count_b;

  int total_checks = 0;
  int bad_checks   = 0;

  // reference model: the open window's sample total/count and the pending result
  bit m_hold    = 0;
  int m_total   = 0;
  int m_cnt     = 0;
  int e_sum_a   = 0;
  int e_sum_b   = 0;
  int e_count   = 0;
  bit e_sat_a   = 0;
  bit e_sat_b   = 0;

  sum_window_accumulator #(.DATA_W(8), .WINDOW(WINDOW), .ACC_W(12)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
    .flush(flush), .out_sum(out_sum_a), .out_count(out_count_a), .out_sat(out_sat_a),
    .out_valid(out_valid_a), .out_ready(out_ready)
  );

  sum_window_accumulator #(.DATA_W(8), .WINDOW(WINDOW), .ACC_W(8)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
    .flush(flush), .out_sum(out_sum_b), .out_count(out_count_b), .out_sat(out_sat_b),
    .out_valid(out_valid_b), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s got=%0d want=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("in_ready_a", in_ready_a, !m_hold);
    checkOutput("in_ready_b", in_ready_b, !m_hold);
    checkOutput("out_valid_a", out_valid_a, m_hold);
    checkOutput("out_valid_b", out_valid_b, m_hold);
    if (m_hold) begin
      checkOutput("out_sum_a", out_sum_a, e_sum_a);
      checkOutput("out_sum_b", out_sum_b, e_sum_b);
      checkOutput("out_count_a", out_count_a, e_count);
      checkOutput("out_count_b", out_count_b, e_count);
      checkOutput("out_sat_a", out_sat_a, e_sat_a);
      checkOutput("out_sat_b", out_sat_b, e_sat_b);
    end
  endtask

  // One clock: drive inputs, advance the model, then sample just after the edge.
  task automatic applyStimulus(input bit v, input int d, input bit f, input bit r);
    bit closing;
    in_valid  = v;
    in_data   = 8'(d);
    flush     = f;
    out_ready = r;
    if (!m_hold) begin
      if (v) begin
        m_total += d;
        m_cnt++;
      end
      closing = (v && m_cnt == WINDOW) || (f && m_cnt > 0);
      if (closing) begin
        e_sum_a = (m_total > MAX_A) ? MAX_A : m_total;
        e_sum_b = (m_total > MAX_B) ? MAX_B : m_total;
        e_sat_a = (m_total > MAX_A);
        e_sat_b = (m_total > MAX_B);
        e_count = m_cnt;
        m_hold  = 1;
        m_total = 0;
        m_cnt   = 0;
      end
    end else if (r) begin
      m_hold = 0;
    end
    @(posedge clk);
    #1;
    checkAll();
  endtask

  task automatic doReset();
    in_valid  = 0;
    flush     = 0;
    out_ready = 0;
    rst       = 1;
    #1;
    m_hold  = 0;
    m_total = 0;
    m_cnt   = 0;
    checkOutput("rst_out_valid", out_valid_a | out_valid_b, 0);
    checkOutput("rst_out_sum", out_sum_a | 12'(out_sum_b), 0);
    checkOutput("rst_out_count", out_count_a | out_count_b, 0);
    checkOutput("rst_out_sat", out_sat_a | out_sat_b, 0);
    @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk);
    #1;
    checkAll();
  endtask

  initial begin
    @(posedge clk);
    #1;
    doReset();

    $display("[TB] back-to-back full window");
    applyStimulus(1, 10, 0, 1);
    applyStimulus(1, 20, 0, 1);
    applyStimulus(1, 30, 0, 1);
    applyStimulus(1, 40, 0, 1);
    checkOutput("t1_sum_100", out_sum_a, 100);
    applyStimulus(0, 0, 0, 1);

    $display("[TB] flushed partial window and empty flush");
    applyStimulus(1, 5, 0, 1);
    applyStimulus(1, 7, 0, 1);
    applyStimulus(0, 0, 1, 1);
    checkOutput("t2_count_2", out_count_a, 2);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 0, 1, 1);

    $display("[TB] saturation then clean window");
    applyStimulus(1, 200, 0, 1);
    applyStimulus(1, 100, 0, 1);
    applyStimulus(0, 0, 1, 1);
    checkOutput("t3_sat_b", out_sat_b, 1);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(1, 10, 1, 1);
    applyStimulus(0, 0, 0, 1);

    $display("[TB] backpressure");
    for (int i = 0; i < 4; i++) applyStimulus(1, 50 + i, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 99, 1, 0);
    applyStimulus(1, 99, 0, 1);
    applyStimulus(0, 0, 0, 0);

    $display("[TB] flush with accept");
    applyStimulus(1, 3, 0, 1);
    applyStimulus(1, 9, 1, 1);
    checkOutput("t5_sum_12", out_sum_a, 12);
    applyStimulus(0, 0, 0, 1);

    $display("[TB] reset mid-window and mid-hold");
    applyStimulus(1, 8, 0, 0);
    applyStimulus(1, 8, 0, 0);
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1, 77, 0, 0);
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0);
    checkOutput("t6_sum_4", out_sum_a, 4);
    applyStimulus(0, 0, 0, 1);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 255),
                    $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
    end

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
